tape_sequencer: RTL and testbench
=================================

Name: tape_sequencer

Overview:
Playback controller for the paper-tape music player. It steps through the tape memory one note entry at a time and holds each note for its encoded number of beats. Beat timing comes from a tempo-programmable beat tick generator. The block handles play, pause, resume and stop, and drives the note code to the downstream tone generator.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz; beat denominator BEAT_DEN = CLK_HZ*60.
ADDR_W, 6, tape address width; tape depth = 2**ADDR_W entries.
NOTE_W, 6, note code width; code 0 = rest.
DUR_W, 3, duration field width in beats; 0 = end-of-tape marker.
TEMPO_W, 8, tempo input width in beats per minute.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
play_btn  in  1  single-cycle pulse; start / pause / resume
stop_btn  in  1  single-cycle pulse; abort and return to address 0
tempo_bpm  in  TEMPO_W  beats per minute; sampled every cycle
tape_addr  out  ADDR_W  tape memory read address
tape_data  in  NOTE_W+DUR_W  tape word {note, dur}; synchronous ROM, 1-cycle latency
note_out  out  NOTE_W  current note code
note_valid  out  1  tone generator enable
playing  out  1  high in FETCH, WAIT_DATA and PLAY
paused  out  1  high in PAUSED
beat_tick  out  1  one-cycle pulse per beat, PLAY state only
done_pulse  out  1  one-cycle pulse on entry to END

Behaviour:
- Reset: state IDLE; tape_addr=0; note_out=0; all 1-bit outputs 0; beat accumulator 0; beats_left 0.
- Beat generator:
  - Runs only in PLAY: acc_next = acc + tempo_bpm.
  - If acc_next >= BEAT_DEN: beat_tick=1 and acc = acc_next - BEAT_DEN; otherwise acc = acc_next.
  - Accumulator width is ceil(log2(BEAT_DEN + 2**TEMPO_W)) bits.
  - tempo_bpm=0 produces no ticks.
  - acc is frozen in FETCH, WAIT_DATA and PAUSED, and cleared in IDLE and END.
- FSM:
  - IDLE: on play_btn, go to FETCH.
  - FETCH: tape_addr is stable; next state is WAIT_DATA.
  - WAIT_DATA: capture tape_data.
    - If dur==0, go to END.
    - Otherwise note_out<=note, beats_left<=dur, note_valid<=1, and go to PLAY.
    - Result: the new note is visible 2 cycles after entering FETCH.
  - PLAY: on each beat_tick, decrement beats_left.
    - On the tick that reaches 0: if tape_addr is all-ones, go to END; otherwise tape_addr++ and go to FETCH.
    - note_out and note_valid are held through FETCH and WAIT_DATA, so there is no gap between notes.
  - PLAY with play_btn: go to PAUSED with note_valid=0. beats_left and acc are retained.
  - PAUSED with play_btn: go to PLAY with note_valid=1, continuing from the same phase.
  - play_btn in FETCH or WAIT_DATA is ignored.
  - END: done_pulse=1 for the entry cycle; note_valid=0. On play_btn, tape_addr=0 and go to FETCH.
- Stop: stop_btn in any state goes to IDLE on the next edge with tape_addr=0 and note_valid=0.
- Simultaneous events:
  - stop_btn beats play_btn in the same cycle.
  - play_btn beats a final beat_tick in the same cycle: the block pauses and the tick is discarded without decrementing.
- Reset mid-operation: same as the reset values, regardless of state.

Optional Feature:
LOOP_PLAYBACK_EN
- Defined: on an end marker or address wrap, tape_addr=0 and the next state is FETCH (continuous loop). done_pulse still fires for one cycle.
  - If the entry at address 0 is itself an end marker, the block goes to END to avoid a livelock.
- Undefined: behaviour is exactly as specified above.

Decomposition:
- Package tape_seq_pkg holds:
  - state enum: IDLE, FETCH, WAIT_DATA, PLAY, PAUSED, END
  - field-extract constants for note and dur within the tape word
  - the END_MARKER value (dur==0)
- One sub-module, beat_tick_gen, contains the accumulator, its enable and clear inputs, and the beat_tick output. The parent holds the FSM and address logic.

Test Plan (CLK_HZ=10 so BEAT_DEN=600; tempo_bpm=60 gives one tick every 10 PLAY cycles):
- Tape {5,2},{7,1},{0,0}; play_btn -> note_out=5 valid 2 cycles later for 20 PLAY cycles; note 7 for 10; then done_pulse once, note_valid=0, END.
- play_btn at PLAY cycle 4, hold 50 cycles, play_btn again -> paused=1 and note_valid=0 throughout; after resume the tick arrives after 6 more PLAY cycles.
- stop_btn and play_btn in the same cycle mid-note -> IDLE, tape_addr=0, note_valid=0.
- tempo_bpm=0 for 100 cycles -> no beat_tick and note held; set tempo_bpm=120 -> ticks every 5 cycles.
- Full tape, 64 entries with dur=1 and no marker -> END after address 63; with LOOP_PLAYBACK_EN, wraps to address 0 and keeps playing.
- rst_n=0 in PLAY -> all outputs at reset values the next cycle; play_btn restarts from address 0.

Source files
------------

// File: rtl/tape_seq_pkg.sv
// Shared types and tape-word field layout for the paper-tape sequencer.
// Tape word is {note, dur}; dur occupies the low bits.
package tape_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitData,
        StPlay,
        StPaused,
        StEnd
    } seq_state_e;

    localparam int unsigned DurLsb    = 0;
    localparam int unsigned EndMarker = 0;

    function automatic int unsigned note_lsb(input int unsigned dur_w);
        return dur_w;
    endfunction

endpackage

// File: rtl/beat_tick_gen.sv
// Tempo-programmable beat generator: adds tempo_bpm every enabled cycle and
// emits one tick per BEAT_DEN accumulated, keeping the remainder as phase.
module beat_tick_gen #(
    parameter longint unsigned BEAT_DEN = 64'd6_000_000_000,
    parameter int unsigned     TEMPO_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [TEMPO_W-1:0] tempo_bpm,
    output logic               beat_tick
);

    localparam int unsigned AccW = $clog2(BEAT_DEN + (64'd1 << TEMPO_W));

    logic [AccW-1:0] acc_q, acc_d;
    logic [AccW:0]   acc_sum;

    always_comb begin
        acc_sum   = {1'b0, acc_q} + (AccW + 1)'(tempo_bpm);
        beat_tick = en && (acc_sum >= (AccW + 1)'(BEAT_DEN));
        acc_d     = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            // Keep the remainder so the beat phase survives pauses and note changes.
            acc_d = beat_tick ? AccW'(acc_sum - (AccW + 1)'(BEAT_DEN)) : AccW'(acc_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/tape_sequencer.sv
// Paper-tape playback controller: fetches {note, dur} entries and holds each note
// for dur beats. Define LOOP_PLAYBACK_EN to restart from address 0 at end of tape.
module tape_sequencer
    import tape_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned NOTE_W  = 6,
    parameter int unsigned DUR_W   = 3,
    parameter int unsigned TEMPO_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    play_btn,
    input  logic                    stop_btn,
    input  logic [TEMPO_W-1:0]      tempo_bpm,
    output logic [ADDR_W-1:0]       tape_addr,
    input  logic [NOTE_W+DUR_W-1:0] tape_data,
    output logic [NOTE_W-1:0]       note_out,
    output logic                    note_valid,
    output logic                    playing,
    output logic                    paused,
    output logic                    beat_tick,
    output logic                    done_pulse
);

    localparam longint unsigned BeatDen = 64'(CLK_HZ) * 64'd60;
    localparam int unsigned     NoteLsb = note_lsb(DUR_W);
`ifdef LOOP_PLAYBACK_EN
    localparam bit LoopEn = 1'b1;
`else
    localparam bit LoopEn = 1'b0;
`endif

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  beats_q, beats_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              tick;
    logic [DUR_W-1:0]  word_dur;
    logic [NOTE_W-1:0] word_note;

    assign word_dur  = tape_data[DurLsb +: DUR_W];
    assign word_note = tape_data[NoteLsb +: NOTE_W];

    beat_tick_gen #(
        .BEAT_DEN (BeatDen),
        .TEMPO_W  (TEMPO_W)
    ) u_beat_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_q == StPlay),
        .clr       ((state_q == StIdle) || (state_q == StEnd)),
        .tempo_bpm (tempo_bpm),
        .beat_tick (tick)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        note_d  = note_q;
        beats_d = beats_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (stop_btn) begin
            state_d = StIdle;
            addr_d  = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (play_btn) state_d = StFetch;
                end
                StFetch: state_d = StWaitData;
                StWaitData: begin
                    if (word_dur == DUR_W'(EndMarker)) begin
                        done_d = 1'b1;
                        // An end marker at address 0 would loop forever, so it always ends.
                        if (LoopEn && (addr_q != '0)) begin
                            addr_d  = '0;
                            state_d = StFetch;
                        end else begin
                            state_d = StEnd;
                            valid_d = 1'b0;
                        end
                    end else begin
                        note_d  = word_note;
                        beats_d = word_dur;
                        valid_d = 1'b1;
                        state_d = StPlay;
                    end
                end
                StPlay: begin
                    if (play_btn) begin
                        state_d = StPaused;
                        valid_d = 1'b0;
                        // A final tick coinciding with pause is dropped, not consumed.
                        if (tick && (beats_q > DUR_W'(1))) beats_d = beats_q - DUR_W'(1);
                    end else if (tick) begin
                        beats_d = beats_q - DUR_W'(1);
                        if (beats_q == DUR_W'(1)) begin
                            if (&addr_q) begin
                                done_d = 1'b1;
                                if (LoopEn) begin
                                    addr_d  = '0;
                                    state_d = StFetch;
                                end else begin
                                    state_d = StEnd;
                                    valid_d = 1'b0;
                                end
                            end else begin
                                addr_d  = addr_q + ADDR_W'(1);
                                state_d = StFetch;
                            end
                        end
                    end
                end
                StPaused: begin
                    if (play_btn) begin
                        state_d = StPlay;
                        valid_d = 1'b1;
                    end
                end
                StEnd: begin
                    if (play_btn) begin
                        addr_d  = '0;
                        state_d = StFetch;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            note_q  <= '0;
            beats_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            beats_q <= beats_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign tape_addr  = addr_q;
    assign note_out   = note_q;
    assign note_valid = valid_q;
    assign playing    = (state_q == StFetch) || (state_q == StWaitData) || (state_q == StPlay);
    assign paused     = (state_q == StPaused);
    assign beat_tick  = tick;
    assign done_pulse = done_q;

endmodule

// File: tb/tb_tape_sequencer.sv
// Self-checking bench for tape_sequencer: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural playback model.
module tb_tape_sequencer;

    localparam int unsigned CLK_HZ  = 10;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned NOTE_W  = 6;
    localparam int unsigned DUR_W   = 3;
    localparam int unsigned TEMPO_W = 8;
    localparam int          Den     = CLK_HZ * 60;
    localparam int          Depth   = 64;
`ifdef LOOP_PLAYBACK_EN
    localparam bit Loop = 1'b1;
`else
    localparam bit Loop = 1'b0;
`endif

    logic                    clk;
    logic                    rst_n;
    logic                    play_btn;
    logic                    stop_btn;
    logic [TEMPO_W-1:0]      tempo_bpm;
    logic [ADDR_W-1:0]       tape_addr;
    logic [NOTE_W+DUR_W-1:0] tape_data;
    logic [NOTE_W-1:0]       note_out;
    logic                    note_valid;
    logic                    playing;
    logic                    paused;
    logic                    beat_tick;
    logic                    done_pulse;

    logic [NOTE_W+DUR_W-1:0] rom [Depth];

    tape_sequencer #(
        .CLK_HZ  (CLK_HZ),
        .ADDR_W  (ADDR_W),
        .NOTE_W  (NOTE_W),
        .DUR_W   (DUR_W),
        .TEMPO_W (TEMPO_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .play_btn   (play_btn),
        .stop_btn   (stop_btn),
        .tempo_bpm  (tempo_bpm),
        .tape_addr  (tape_addr),
        .tape_data  (tape_data),
        .note_out   (note_out),
        .note_valid (note_valid),
        .playing    (playing),
        .paused     (paused),
        .beat_tick  (beat_tick),
        .done_pulse (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) tape_data <= rom[tape_addr];

    int vectors = 0;
    int errors  = 0;
    bit last_tick;

    // Behavioural model: playback mode plus plain integer beat phase.
    localparam int MIdle = 0, MLoad1 = 1, MLoad2 = 2, MPlay = 3, MPause = 4, MEnd = 5;
    int m_mode, m_addr, m_note, m_beats, m_acc;
    bit m_valid, m_done, m_ok;

    task automatic model_check();
        bit tk;
        bit exp_playing;
        tk = (m_mode == MPlay) && (m_acc + int'(tempo_bpm) >= Den);
        exp_playing = (m_mode == MLoad1) || (m_mode == MLoad2) || (m_mode == MPlay);
        vectors++;
        if (int'(tape_addr) != m_addr || int'(note_out) != m_note || note_valid != m_valid ||
            playing != exp_playing || paused != (m_mode == MPause) || beat_tick != tk ||
            done_pulse != m_done) begin
            errors++;
            $display("FAIL model t=%0t: got addr=%0d note=%0d valid=%0b playing=%0b paused=%0b tick=%0b done=%0b; required addr=%0d note=%0d valid=%0b playing=%0b paused=%0b tick=%0b done=%0b",
                     $time, tape_addr, note_out, note_valid, playing, paused, beat_tick,
                     done_pulse, m_addr, m_note, m_valid, exp_playing, (m_mode == MPause), tk,
                     m_done);
        end
    endtask

    task automatic model_step();
        bit tk;
        bit nd;
        int dur, note;
        tk = (m_mode == MPlay) && (m_acc + int'(tempo_bpm) >= Den);
        nd = 1'b0;
        if (m_mode == MPlay) m_acc = tk ? m_acc + int'(tempo_bpm) - Den : m_acc + int'(tempo_bpm);
        if (m_mode == MIdle || m_mode == MEnd) m_acc = 0;
        if (stop_btn) begin
            m_mode = MIdle; m_addr = 0; m_valid = 1'b0;
        end else begin
            case (m_mode)
                MIdle:  if (play_btn) m_mode = MLoad1;
                MLoad1: m_mode = MLoad2;
                MLoad2: begin
                    dur  = int'(rom[m_addr]) % 8;
                    note = int'(rom[m_addr]) / 8;
                    if (dur == 0) begin
                        nd = 1'b1;
                        if (Loop && m_addr != 0) begin
                            m_addr = 0; m_mode = MLoad1;
                        end else begin
                            m_mode = MEnd; m_valid = 1'b0;
                        end
                    end else begin
                        m_note = note; m_beats = dur; m_valid = 1'b1; m_mode = MPlay;
                    end
                end
                MPlay: begin
                    if (play_btn) begin
                        m_mode = MPause; m_valid = 1'b0;
                        if (tk && m_beats > 1) m_beats--;
                    end else if (tk) begin
                        m_beats--;
                        if (m_beats == 0) begin
                            if (m_addr == Depth - 1) begin
                                nd = 1'b1;
                                if (Loop) begin
                                    m_addr = 0; m_mode = MLoad1;
                                end else begin
                                    m_mode = MEnd; m_valid = 1'b0;
                                end
                            end else begin
                                m_addr++; m_mode = MLoad1;
                            end
                        end
                    end
                end
                MPause: if (play_btn) begin m_mode = MPlay; m_valid = 1'b1; end
                MEnd:   if (play_btn) begin m_addr = 0; m_mode = MLoad1; end
                default: m_mode = MIdle;
            endcase
        end
        m_done = nd;
    endtask

    // One clock: drive inputs, check at the falling edge, then advance past the rising edge.
    task automatic cyc(input bit p, input bit s, input int t, input bit r);
        play_btn  = p;
        stop_btn  = s;
        tempo_bpm = TEMPO_W'(t);
        rst_n     = r;
        @(negedge clk);
        last_tick = beat_tick;
        if (m_ok) model_check();
        if (!r) begin
            m_mode = MIdle; m_addr = 0; m_note = 0; m_beats = 0; m_acc = 0;
            m_valid = 1'b0; m_done = 1'b0; m_ok = 1'b1;
        end else if (m_ok) begin
            model_step();
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit rst; bit play; bit stop; int tempo; int cycles;
        int note; bit valid; bit playing; bit paused; bit done; int addr;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(bit rst, bit play, bit stop, int tempo, int cycles, int note,
                                bit valid, bit pl, bit pa, bit done, int addr);
        vec_t v;
        v.rst = rst; v.play = play; v.stop = stop; v.tempo = tempo; v.cycles = cycles;
        v.note = note; v.valid = valid; v.playing = pl; v.paused = pa; v.done = done;
        v.addr = addr;
        return v;
    endfunction

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            cyc(tbl[i].play, tbl[i].stop, tbl[i].tempo, !tbl[i].rst);
            for (int c = 1; c < tbl[i].cycles; c++) cyc(1'b0, 1'b0, tbl[i].tempo, 1'b1);
            vectors++;
            if (int'(note_out) != tbl[i].note || note_valid != tbl[i].valid ||
                playing != tbl[i].playing || paused != tbl[i].paused ||
                done_pulse != tbl[i].done || int'(tape_addr) != tbl[i].addr) begin
                errors++;
                $display("FAIL row%0d: got note=%0d valid=%0b playing=%0b paused=%0b done=%0b addr=%0d; required note=%0d valid=%0b playing=%0b paused=%0b done=%0b addr=%0d",
                         i, note_out, note_valid, playing, paused, done_pulse, tape_addr,
                         tbl[i].note, tbl[i].valid, tbl[i].playing, tbl[i].paused,
                         tbl[i].done, tbl[i].addr);
            end
        end
    endtask

    // Returns the number of cycles until beat_tick is seen (0 if bound expires).
    task automatic cycles_to_tick(input int tempo, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b0, 1'b0, tempo, 1'b1);
            if (last_tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic expect_int(input string name, input int got, input int req);
        vectors++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    initial begin
        int n;
        bit seen;
        int tempo;
        m_ok = 1'b0;
        play_btn = 1'b0; stop_btn = 1'b0; tempo_bpm = 8'd60; rst_n = 1'b0;
        for (int i = 0; i < Depth; i++) rom[i] = '0;
        rom[0] = {6'd5, 3'd2};
        rom[1] = {6'd7, 3'd1};
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 60, 1'b0);
        cyc(1'b0, 1'b0, 60, 1'b0);
        expect_int("reset_state", {26'd0, note_out, note_valid, playing, paused, done_pulse} +
                   int'(tape_addr), 0);

        tbl[0]  = mk(0, 1, 0, 60, 1,   0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 60, 1,   0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 60, 1,   5, 1, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 60, 19,  5, 1, 1, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 60, 1,   5, 1, 1, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 60, 1,   5, 1, 1, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0, 60, 1,   7, 1, 1, 0, 0, 1);
        tbl[7]  = mk(0, 0, 0, 60, 9,   7, 1, 1, 0, 0, 1);
        tbl[8]  = mk(0, 0, 0, 60, 1,   7, 1, 1, 0, 0, 2);
        tbl[9]  = mk(0, 0, 0, 60, 1,   7, 1, 1, 0, 0, 2);
        tbl[10] = mk(0, 0, 0, 60, 1,   7, 0, 0, 0, 1, 2);
        tbl[11] = mk(0, 0, 0, 60, 1,   7, 0, 0, 0, 0, 2);
        tbl[12] = mk(0, 1, 0, 60, 1,   7, 0, 1, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 60, 1,   7, 0, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 60, 1,   5, 1, 1, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 60, 3,   5, 1, 1, 0, 0, 0);
        tbl[16] = mk(0, 1, 0, 60, 1,   5, 0, 0, 1, 0, 0);
        tbl[17] = mk(0, 0, 0, 60, 50,  5, 0, 0, 1, 0, 0);
        tbl[18] = mk(0, 1, 0, 60, 1,   5, 1, 1, 0, 0, 0);
        tbl[19] = mk(0, 0, 0, 60, 13,  7, 1, 1, 0, 0, 1);
        tbl[20] = mk(0, 1, 1, 60, 1,   7, 0, 0, 0, 0, 0);
        tbl[21] = mk(0, 1, 0, 0,  1,   7, 0, 1, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 0,  1,   7, 0, 1, 0, 0, 0);
        tbl[23] = mk(0, 0, 0, 0,  1,   5, 1, 1, 0, 0, 0);
        tbl[24] = mk(0, 0, 0, 0,  100, 5, 1, 1, 0, 0, 0);
        tbl[25] = mk(0, 0, 0, 60, 2,   7, 1, 1, 0, 0, 1);
        tbl[26] = mk(1, 0, 0, 60, 1,   0, 0, 0, 0, 0, 0);
        tbl[27] = mk(0, 1, 0, 60, 1,   0, 0, 1, 0, 0, 0);
        tbl[28] = mk(0, 0, 0, 60, 2,   5, 1, 1, 0, 0, 0);
        tbl[29] = mk(0, 0, 1, 60, 1,   5, 0, 0, 0, 0, 0);

        run_rows(0, 18);
        cycles_to_tick(60, n);
        expect_int("resume_tick_phase", n, 6);
        run_rows(19, 24);
        cycles_to_tick(120, n);
        expect_int("tempo120_first_tick", n, 5);
        cycles_to_tick(120, n);
        expect_int("tempo120_second_tick", n, 5);
        run_rows(25, 29);

        // Full tape with no end marker.
        for (int i = 0; i < Depth; i++) rom[i] = {6'((i % 63) + 1), 3'd1};
        cyc(1'b1, 1'b0, 255, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            cyc(1'b0, 1'b0, 255, 1'b1);
            seen = done_pulse;
        end
        expect_int("full_tape_done_seen", int'(seen), 1);
        expect_int("full_tape_done_addr", int'(tape_addr), Loop ? 0 : Depth - 1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 255, 1'b1);
        expect_int("full_tape_after_playing", int'(playing), int'(Loop));
        cyc(1'b0, 1'b1, 255, 1'b1);

        // Randomized play/pause/stop/tempo/reset against the model.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < Depth; i++)
                rom[i] = {6'($urandom), ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7))};
            tempo = 200;
            for (int c = 0; c < 4000; c++) begin
                if ($urandom_range(0, 199) == 0) begin
                    case ($urandom_range(0, 4))
                        0: tempo = 0;
                        1: tempo = 60;
                        2: tempo = 255;
                        default: tempo = int'($urandom_range(0, 255));
                    endcase
                end
                cyc($urandom_range(0, 29) == 0, $urandom_range(0, 399) == 0, tempo,
                    $urandom_range(0, 1499) != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
